// File: rtl/data_cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped data cache.
package data_cache_pkg;
   localparam int unsigned TAG_W      = 3;
   localparam int unsigned INDEX_W    = 3;
   localparam int unsigned OFFSET_W   = 2;
   localparam int unsigned NUM_BLOCKS = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   function automatic logic [7:0] get_byte(input logic [31:0] blk, input logic [OFFSET_W-1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port
// (byte store or whole-block fill), valid/dirty cleared on RESET.
module dcache_array
   import data_cache_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic [INDEX_W-1:0]  index,
   output logic                valid,
   output logic                dirty,
   output logic [TAG_W-1:0]    tag,
   output logic [31:0]         data,
   input  logic                byte_we,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [7:0]          byte_data,
   input  logic                fill_we,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [31:0]         fill_data
);
   logic [NUM_BLOCKS-1:0] valid_q;
   logic [NUM_BLOCKS-1:0] dirty_q;
   logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
   logic [31:0]           data_q [NUM_BLOCKS];

   assign valid = valid_q[index];
   assign dirty = dirty_q[index];
   assign tag   = tag_q[index];
   assign data  = data_q[index];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (byte_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tag and data are not reset; valid gates their use.
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         tag_q[index]  <= fill_tag;
         data_q[index] <= fill_data;
      end else if (byte_we) begin
         data_q[index][{offset, 3'b000} +: 8] <= byte_data;
      end
   end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a
// 32-bit-block memory; stalls the CPU through BUSYWAIT.
module data_cache
   import data_cache_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);
   state_t state;
   logic   served;

   logic [TAG_W-1:0]    a_tag;
   logic [INDEX_W-1:0]  a_index;
   logic [OFFSET_W-1:0] a_offset;
   logic                blk_valid, blk_dirty;
   logic [TAG_W-1:0]    blk_tag;
   logic [31:0]         blk_data;
   logic                hit, pending, byte_we, fill_we;

   assign a_tag    = ADDRESS[7:5];
   assign a_index  = ADDRESS[4:2];
   assign a_offset = ADDRESS[1:0];

   assign hit      = blk_valid && (blk_tag == a_tag);
   // served marks the cycle after a hit resolved, so the held request is not re-run.
   assign pending  = (READ || WRITE) && !served;
   assign BUSYWAIT = pending;
   assign byte_we  = (state == IDLE) && pending && hit && WRITE;
   assign fill_we  = (state == UPDATE);
   assign READDATA = hit ? get_byte(blk_data, a_offset) : '0;

   dcache_array u_array (
      .CLK       (CLK),
      .RESET     (RESET),
      .index     (a_index),
      .valid     (blk_valid),
      .dirty     (blk_dirty),
      .tag       (blk_tag),
      .data      (blk_data),
      .byte_we   (byte_we),
      .offset    (a_offset),
      .byte_data (WRITEDATA),
      .fill_we   (fill_we),
      .fill_tag  (a_tag),
      .fill_data (MEM_READDATA)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         served <= 1'b0;
      end else begin
         served <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pending) begin
                  if (hit)
                     served <= 1'b1;
                  else if (blk_valid && blk_dirty)
                     state <= WRITEBACK;
                  else
                     state <= FETCH;
               end
            end
            WRITEBACK: if (!MEM_BUSYWAIT) state <= FETCH;
            FETCH:     if (!MEM_BUSYWAIT) state <= UPDATE;
            UPDATE:    state <= IDLE;
         endcase
      end
   end

   always_comb begin
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      unique case (state)
         WRITEBACK: begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {blk_tag, a_index};
            MEM_WRITEDATA = blk_data;
         end
         FETCH: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = ADDRESS[7:2];
         end
         default: ;
      endcase
   end
endmodule
